// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard path.
//   - set-2 scan-code constants used by the byte decoder
//   - receiver FSM state encoding
//   - is_filler(): bytes the keyboard sends that carry no key event
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_OVR0   = 8'h00;
   localparam logic [7:0] SC_OVR1   = 8'hFF;

   // Bytes following E1 that belong to the pause sequence.
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_t;

   function automatic logic is_filler(input logic [7:0] b);
      return (b == SC_OVR0) || (b == SC_BAT) || (b == SC_ECHO) ||
             (b == SC_ACK) || (b == SC_RESEND) || (b == SC_OVR1);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 frame receiver (start, 8 data LSB first, odd parity, stop).
//   Synchronizes and glitch-filters the PS/2 pins, samples data on each
//   filtered falling clock edge, aborts a stalled frame after TIMEOUT_CYC.
// Ports:
//   pclk, rst_n      clock, async active-low reset
//   ps2_clk/ps2_data raw asynchronous pins
//   byte_valid       one-cycle pulse, rx_byte holds the received byte
//   rx_byte          last received byte
//   frame_err        one-cycle pulse on bad stop, timeout, or (optionally) parity
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad parity.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data low on a falling edge)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking the stop bit, then emitting byte or error
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_CHECK = 1'b1;
`else
   localparam bit PARITY_CHECK = 1'b0;
`endif

   logic [1:0]    clk_sync, data_sync;
   logic          clk_filt, fall_tick;
   logic [FW-1:0] filt_cnt;
   logic [TW-1:0] to_cnt;
   rx_state_t     state, state_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shift_reg, shift_nxt;
   logic          par_bit, par_nxt;
   logic          byte_ok, bad_frame, timeout, par_ok;

   // Idle bus level is high, so synchronizers and filter reset to 1.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_filt  <= 1'b1;
         filt_cnt  <= '0;
         fall_tick <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         fall_tick <= 1'b0;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt  <= clk_sync[1];
            filt_cnt  <= '0;
            fall_tick <= clk_filt;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (fall_tick)
         to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYC))
         to_cnt <= to_cnt + TW'(1);
   end

   assign timeout = (state != RX_IDLE) && !fall_tick && (to_cnt == TW'(TIMEOUT_CYC));
   assign par_ok  = !PARITY_CHECK || (^{shift_reg, par_bit});

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_reg;
      par_nxt     = par_bit;
      byte_ok     = 1'b0;
      bad_frame   = 1'b0;
      if (timeout) begin
         state_nxt = RX_IDLE;
         bad_frame = 1'b1;
      end else if (fall_tick) begin
         case (state)
            RX_IDLE: begin
               if (!data_sync[1]) begin
                  state_nxt   = RX_DATA;
                  bit_cnt_nxt = 3'd0;
               end
            end
            RX_DATA: begin
               shift_nxt   = {data_sync[1], shift_reg[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_nxt = RX_PARITY;
            end
            RX_PARITY: begin
               par_nxt   = data_sync[1];
               state_nxt = RX_STOP;
            end
            RX_STOP: begin
               state_nxt = RX_IDLE;
               if (data_sync[1] && par_ok)
                  byte_ok = 1'b1;
               else
                  bad_frame = 1'b1;
            end
            default: state_nxt = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RX_IDLE;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'h00;
         par_bit    <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift_reg  <= shift_nxt;
         par_bit    <= par_nxt;
         byte_valid <= byte_ok;
         frame_err  <= bad_frame;
      end
   end

   // shift_reg is untouched in STOP/IDLE, so it is stable while byte_valid is high.
   assign rx_byte = shift_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 keyboard state tracker for the game logic.
//   Decodes E0 (extended), F0 (break) and E1 (pause, swallowed) prefixes
//   and keeps one held-bit per {ext,code}.
// Ports:
//   pclk, rst_n       clock, async active-low reset
//   ps2_clk/ps2_data  raw PS/2 pins
//   key_down[511:0]   bit {ext,code} set while that key is held
//   last_change[8:0]  {ext,code} of the latest make or break
//   key_valid         one-cycle pulse when key_down/last_change update
//   frame_err         one-cycle pulse on a dropped frame
// Build option: PS2_PARITY_CHECK_EN (see ps2_rx_frame) enables parity drop.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic         pclk,
   input  logic         rst_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [511:0] key_down,
   output logic [8:0]   last_change,
   output logic         key_valid,
   output logic         frame_err
);

   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       ext, brk;
   logic [2:0] skip;

   ps2_rx_frame #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   // Any dropped frame leaves the prefix context unknown, so start clean.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         key_down    <= '0;
         last_change <= 9'h000;
         key_valid   <= 1'b0;
         ext         <= 1'b0;
         brk         <= 1'b0;
         skip        <= 3'd0;
      end else begin
         key_valid <= 1'b0;
         if (frame_err) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= 3'd0;
         end else if (byte_valid) begin
            if (skip != 3'd0) begin
               skip <= skip - 3'd1;
            end else if (rx_byte == SC_PAUSE) begin
               skip <= PAUSE_SKIP;
            end else if (rx_byte == SC_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
               brk <= 1'b1;
            end else if (is_filler(rx_byte)) begin
               ext <= 1'b0;
               brk <= 1'b0;
            end else begin
               key_down[{ext, rx_byte}] <= !brk;
               last_change              <= {ext, rx_byte};
               key_valid                <= 1'b1;
               ext                      <= 1'b0;
               brk                      <= 1'b0;
            end
         end
      end
   end

endmodule
